// File: rtl/ocm_arb_pkg.sv
// Shared types for the on-chip memory arbiter: FSM states, requester ids, read-tag pipe entries.
package ocm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/ocm_rd_tag_pipe.sv
// Shift register of {valid, id} tags, DEPTH stages deep, tracking which requester owns each in-flight read.
// Output appears DEPTH cycles after input; no backpressure, synchronous active-low clear.
module ocm_rd_tag_pipe
  import ocm_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    clr_n,
  input  rd_tag_t in_tag,
  output rd_tag_t out_tag
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_tag = stage[DEPTH-1];

endmodule

// File: rtl/ocm_dual_port_arbiter.sv
// Shares one single-port memory between requesters A and B with sticky round-robin and a bounded hold.
// Commands pass through combinationally; the loser sees waitrequest; read data returns RD_LATENCY cycles later.
module ocm_dual_port_arbiter
  import ocm_arb_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int BE_W       = 4,
  parameter int MAX_HOLD   = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  input  logic [BE_W-1:0]   a_byteenable,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,

  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  input  logic [BE_W-1:0]   b_byteenable,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  arb_state_e state, state_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic       req_a, req_b;
  logic       grant_a, grant_b;
  rd_tag_t    tag_in, tag_out;
  logic       vld_a, vld_b;

  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // The hold limit only matters when both sides want the memory.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    state_nxt = state;
    hold_nxt  = hold_cnt;

    case (state)
      OWN_A: begin
        grant_a = req_a & ((hold_cnt < HOLD_LIM) | ~req_b);
        grant_b = ~grant_a & req_b;
      end
      OWN_B: begin
        grant_b = req_b & ((hold_cnt < HOLD_LIM) | ~req_a);
        grant_a = ~grant_b & req_a;
      end
      default: begin
        grant_a = req_a;
        grant_b = ~req_a & req_b;
      end
    endcase

    if (!reset_n) begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end

    if (grant_a) begin
      if (state == OWN_A) begin
        hold_nxt = (hold_cnt >= HOLD_LIM) ? HOLD_LIM : hold_cnt + 8'd1;
      end else begin
        state_nxt = OWN_A;
        hold_nxt  = 8'd1;
      end
    end else if (grant_b) begin
      if (state == OWN_B) begin
        hold_nxt = (hold_cnt >= HOLD_LIM) ? HOLD_LIM : hold_cnt + 8'd1;
      end else begin
        state_nxt = OWN_B;
        hold_nxt  = 8'd1;
      end
    end else begin
      hold_nxt = '0;
    end
  end

  always_comb begin
    mem_chipselect = grant_a | grant_b;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    if (grant_a) begin
      mem_write      = a_write;
      mem_address    = a_address;
      mem_writedata  = a_writedata;
      mem_byteenable = a_byteenable;
    end else if (grant_b) begin
      mem_write      = b_write;
      mem_address    = b_address;
      mem_writedata  = b_writedata;
      mem_byteenable = b_byteenable;
    end
  end

  assign a_waitrequest = ~reset_n | (req_a & ~grant_a);
  assign b_waitrequest = ~reset_n | (req_b & ~grant_b);

  // A simultaneous read+write is issued as a write, so it must not create a read tag.
  assign tag_in.valid = (grant_a & ~a_write) | (grant_b & ~b_write);
  assign tag_in.id    = grant_b ? ID_B : ID_A;

  ocm_rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .clr_n   (reset_n),
    .in_tag  (tag_in),
    .out_tag (tag_out)
  );

  assign vld_a = reset_n & tag_out.valid & (tag_out.id == ID_A);
  assign vld_b = reset_n & tag_out.valid & (tag_out.id == ID_B);

  assign a_readdatavalid = vld_a;
  assign b_readdatavalid = vld_b;
  assign a_readdata      = vld_a ? mem_readdata : '0;
  assign b_readdata      = vld_b ? mem_readdata : '0;

endmodule

// File: tb/tb_ocm_dual_port_arbiter.sv
// Bench for ocm_dual_port_arbiter: directed vector table, contention/hold sequences, and random traffic vs a reference model.
module tb_ocm_dual_port_arbiter;

  localparam int ADDR_W   = 14;
  localparam int MAX_HOLD = 4;
  localparam int RD_LAT   = 1;
  localparam int MEM_W    = 1 << ADDR_W;

  logic        clk;
  logic        reset_n;
  logic [13:0] a_address, b_address, mem_address;
  logic        a_read, a_write, b_read, b_write;
  logic [31:0] a_writedata, b_writedata, mem_writedata;
  logic [3:0]  a_byteenable, b_byteenable, mem_byteenable;
  logic        a_waitrequest, b_waitrequest;
  logic [31:0] a_readdata, b_readdata, mem_readdata;
  logic        a_readdatavalid, b_readdatavalid;
  logic        mem_chipselect, mem_write;

  ocm_dual_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(32), .BE_W(4), .MAX_HOLD(MAX_HOLD), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .a_address(a_address), .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
    .a_byteenable(a_byteenable), .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
    .b_byteenable(b_byteenable), .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] be);
    merge = old;
    for (int i = 0; i < 4; i++) if (be[i]) merge[8*i +: 8] = wd[8*i +: 8];
  endfunction

  // Simple single-port memory with RD_LAT cycles of read latency.
  bit [31:0] ram [0:MEM_W-1];
  bit [31:0] rd_sh [RD_LAT];
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
    rd_sh[0] <= ram[mem_address];
    for (int i = 1; i < RD_LAT; i++) rd_sh[i] <= rd_sh[i-1];
  end
  assign mem_readdata = rd_sh[RD_LAT-1];

  typedef struct {
    bit        rst_n;
    bit        ard, awr;
    bit [13:0] aad;
    bit [31:0] awd;
    bit [3:0]  abe;
    bit        brd, bwr;
    bit [13:0] bad;
    bit [31:0] bwd;
    bit [3:0]  bbe;
    bit        xaw, xbw, xarv, xbrv;
    bit [31:0] xrd;
  } vec_t;

  typedef struct {
    int        due;
    bit        id;
    bit [31:0] data;
  } pend_t;

  int        checks = 0;
  int        errors = 0;
  int        cyc    = 0;
  int        owner  = 0;
  int        run    = 0;
  pend_t     pq[$];
  bit [31:0] mdl_mem [0:MEM_W-1];
  vec_t      tbl [24];

  function automatic vec_t mk(input bit [31:0] rst, ard, awr, aad, awd, abe,
                              brd, bwr, bad, bwd, bbe, xaw, xbw, xarv, xbrv, xrd);
    vec_t v;
    v.rst_n = rst[0]; v.ard = ard[0]; v.awr = awr[0]; v.aad = aad[13:0]; v.awd = awd; v.abe = abe[3:0];
    v.brd = brd[0]; v.bwr = bwr[0]; v.bad = bad[13:0]; v.bwd = bwd; v.bbe = bbe[3:0];
    v.xaw = xaw[0]; v.xbw = xbw[0]; v.xarv = xarv[0]; v.xbrv = xbrv[0]; v.xrd = xrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // mask bit0: table waitrequests, bit1: table readdatavalids, bit2: table read data.
  task automatic run_cycle(input vec_t v, input bit [2:0] mask);
    int        win;
    bit        ra, rb, w_wr, earv, ebrv;
    bit [13:0] w_ad;
    bit [31:0] w_wd, edata;
    bit [3:0]  w_be;
    pend_t     p;
    reset_n = v.rst_n;
    a_read = v.ard; a_write = v.awr; a_address = v.aad; a_writedata = v.awd; a_byteenable = v.abe;
    b_read = v.brd; b_write = v.bwr; b_address = v.bad; b_writedata = v.bwd; b_byteenable = v.bbe;
    @(negedge clk);
    ra = v.ard | v.awr;
    rb = v.brd | v.bwr;
    win = 0;
    if (v.rst_n) begin
      if (owner == 1)      win = (ra && (run < MAX_HOLD || !rb)) ? 1 : (rb ? 2 : 0);
      else if (owner == 2) win = (rb && (run < MAX_HOLD || !ra)) ? 2 : (ra ? 1 : 0);
      else                 win = ra ? 1 : (rb ? 2 : 0);
    end
    w_wr = 0; w_ad = 0; w_wd = 0; w_be = 0;
    if (win == 1) begin w_wr = v.awr; w_ad = v.aad; w_wd = v.awd; w_be = v.abe; end
    if (win == 2) begin w_wr = v.bwr; w_ad = v.bad; w_wd = v.bwd; w_be = v.bbe; end
    earv = 0; ebrv = 0; edata = 0;
    if (v.rst_n && pq.size() > 0 && pq[0].due == cyc) begin
      if (pq[0].id) ebrv = 1; else earv = 1;
      edata = pq[0].data;
    end
    chk("a_waitrequest", 32'(a_waitrequest), 32'(!v.rst_n || (ra && win != 1)));
    chk("b_waitrequest", 32'(b_waitrequest), 32'(!v.rst_n || (rb && win != 2)));
    chk("a_readdatavalid", 32'(a_readdatavalid), 32'(earv));
    chk("b_readdatavalid", 32'(b_readdatavalid), 32'(ebrv));
    chk("a_readdata", a_readdata, earv ? edata : 32'h0);
    chk("b_readdata", b_readdata, ebrv ? edata : 32'h0);
    chk("mem_chipselect", 32'(mem_chipselect), 32'(win != 0));
    chk("mem_write", 32'(mem_write), 32'(w_wr));
    chk("mem_address", 32'(mem_address), 32'(w_ad));
    chk("mem_writedata", mem_writedata, w_wd);
    chk("mem_byteenable", 32'(mem_byteenable), 32'(w_be));
    if (mask[0]) begin
      chk("vec_a_wait", 32'(a_waitrequest), 32'(v.xaw));
      chk("vec_b_wait", 32'(b_waitrequest), 32'(v.xbw));
    end
    if (mask[1]) begin
      chk("vec_a_rdv", 32'(a_readdatavalid), 32'(v.xarv));
      chk("vec_b_rdv", 32'(b_readdatavalid), 32'(v.xbrv));
    end
    if (mask[2]) begin
      chk("vec_a_rdata", a_readdata, v.xarv ? v.xrd : 32'h0);
      chk("vec_b_rdata", b_readdata, v.xbrv ? v.xrd : 32'h0);
    end
    if (v.ard && v.awr) $display("note: cycle %0d requester A drove read and write together (illegal)", cyc);
    if (v.brd && v.bwr) $display("note: cycle %0d requester B drove read and write together (illegal)", cyc);
    // Advance the reference model across the coming clock edge.
    if (pq.size() > 0 && pq[0].due <= cyc) void'(pq.pop_front());
    if (!v.rst_n) begin
      owner = 0; run = 0; pq.delete();
    end else if (win != 0) begin
      if (w_wr) mdl_mem[w_ad] = merge(mdl_mem[w_ad], w_wd, w_be);
      else begin
        p.due = cyc + RD_LAT; p.id = (win == 2); p.data = mdl_mem[w_ad];
        pq.push_back(p);
      end
      if (win == owner) run++;
      else begin owner = win; run = 1; end
    end else begin
      run = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   both;
    //              rst ard awr aad    awd           abe  brd bwr bad    bwd           bbe  xaw xbw xarv xbrv xrd
    tbl[0]  = mk(0, 1, 0, 'h10, 0,            'hF, 0, 0, 0,     0,            0,   1, 1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0,     0,            0,   0, 0, 0,     0,            0,   1, 1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 1, 'h10, 'hDEADBEEF,   'hF, 0, 0, 0,     0,            0,   0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 'h10, 0,            'hF, 0, 0, 0,     0,            0,   0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0,     0,            0,   0, 0, 0,     0,            0,   0, 0, 1, 0, 'hDEADBEEF);
    tbl[5]  = mk(1, 0, 1, 'h20, 'h11223344,   'hF, 0, 0, 0,     0,            0,   0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 1, 'h20, 'hAABBCCDD,   'h4, 0, 0, 0,     0,            0,   0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 'h20, 0,            'hF, 0, 0, 0,     0,            0,   0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0,     0,            0,   0, 0, 0,     0,            0,   0, 0, 1, 0, 'h11BB3344);
    tbl[9]  = mk(0, 0, 0, 0,     0,            0,   0, 0, 0,     0,            0,   1, 1, 0, 0, 0);
    tbl[10] = mk(1, 1, 0, 'h10, 0,            'hF, 1, 0, 'h20, 0,            'hF, 0, 1, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0,     0,            0,   1, 0, 'h20, 0,            'hF, 0, 0, 1, 0, 'hDEADBEEF);
    tbl[12] = mk(1, 0, 0, 0,     0,            0,   0, 0, 0,     0,            0,   0, 0, 0, 1, 'h11BB3344);
    tbl[13] = mk(1, 1, 0, 'h10, 0,            'hF, 0, 0, 0,     0,            0,   0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0,     0,            0,   0, 0, 0,     0,            0,   1, 1, 0, 0, 0);
    tbl[15] = mk(1, 0, 0, 0,     0,            0,   0, 0, 0,     0,            0,   0, 0, 0, 0, 0);
    tbl[16] = mk(1, 1, 0, 'h10, 0,            'hF, 0, 0, 0,     0,            0,   0, 0, 0, 0, 0);
    tbl[17] = mk(1, 0, 0, 0,     0,            0,   0, 0, 0,     0,            0,   0, 0, 1, 0, 'hDEADBEEF);
    tbl[18] = mk(1, 1, 1, 'h30, 'h55,         'hF, 0, 0, 0,     0,            0,   0, 0, 0, 0, 0);
    tbl[19] = mk(1, 1, 0, 'h30, 0,            'hF, 0, 0, 0,     0,            0,   0, 0, 0, 0, 0);
    tbl[20] = mk(1, 0, 0, 0,     0,            0,   0, 0, 0,     0,            0,   0, 0, 1, 0, 'h55);
    tbl[21] = mk(1, 0, 0, 0,     0,            0,   0, 1, 'h40, 'hCAFEF00D,   'hF, 0, 0, 0, 0, 0);
    tbl[22] = mk(1, 0, 0, 0,     0,            0,   1, 0, 'h40, 0,            'hF, 0, 0, 0, 0, 0);
    tbl[23] = mk(1, 0, 0, 0,     0,            0,   0, 0, 0,     0,            0,   0, 0, 0, 1, 'hCAFEF00D);

    reset_n = 1'b0;
    a_read = 0; a_write = 0; a_address = 0; a_writedata = 0; a_byteenable = 0;
    b_read = 0; b_write = 0; b_address = 0; b_writedata = 0; b_byteenable = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) run_cycle(tbl[i], 3'b111);

    // Contention: both stream reads from IDLE; expect A x4, B x4, A x4.
    run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 3'b011);
    for (int i = 0; i < 12; i++) begin
      v = mk(1, 1, 0, $urandom_range(0, 63), 0, 'hF, 1, 0, $urandom_range(0, 63), 0, 'hF,
             (i >= 4 && i < 8), !(i >= 4 && i < 8),
             (i >= 1 && i <= 4) || (i >= 9), (i >= 5 && i <= 8), 0);
      run_cycle(v, 3'b011);
    end

    // Lone owner: A streams with B idle, then B arrives with the hold exhausted.
    for (int i = 0; i < 20; i++)
      run_cycle(mk(1, 1, 0, i, 0, 'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 3'b001);
    run_cycle(mk(1, 1, 0, 5, 0, 'hF, 1, 0, 6, 0, 'hF, 1, 0, 0, 0, 0), 3'b001);
    run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 3'b000);

    // Random traffic against the reference model, with occasional resets and contention bursts.
    for (int i = 0; i < 3000; i++) begin
      int oa, ob;
      both = ($urandom_range(0, 3) == 0);
      oa = both ? $urandom_range(4, 9) : $urandom_range(0, 9);
      ob = both ? $urandom_range(4, 9) : $urandom_range(0, 9);
      v = mk(($urandom_range(0, 127) != 0),
             (oa >= 3 && oa <= 6), (oa >= 7), $urandom_range(0, 15), $urandom, $urandom_range(0, 15),
             (ob >= 3 && ob <= 6), (ob >= 7), $urandom_range(0, 15), $urandom, $urandom_range(0, 15),
             0, 0, 0, 0, 0);
      run_cycle(v, 3'b000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
